// File: rtl/uart_mem_loader.sv
// ---------------------------------------------------------------------------
// uart_mem_loader
//
// Boot loader that sits between async_receiver and the memory write port.
// It parses a length-prefixed frame arriving as byte strobes, packs the data
// bytes into memory words (first byte lands in the most significant lane) and
// issues one write strobe per completed word. The CPU is held in stall while
// a frame is open; it regains the memory port when cpu_hold drops.
//
// Frame: LEN_HI, LEN_LO (word count N, big-endian), N*WORD_BYTES data bytes,
//        then one checksum byte when LOADER_CHECKSUM_EN is defined.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   -> trailing XOR checksum byte required, err_code 3 possible
//   undefined -> no checksum state or logic; the last word goes to DONE
//
// Ports:
//   clk        in   system clock (10 MHz nominal)
//   rst        in   synchronous active-high reset
//   start      in   one-cycle pulse, arms the loader (ignored while busy)
//   rx_ready   in   byte strobe from async_receiver
//   rx_data    in   received byte, valid with rx_ready
//   mem_we     out  memory write strobe, one cycle per word
//   mem_addr   out  word address for mem_we
//   mem_wdata  out  word data for mem_we
//   cpu_hold   out  stall request to the CPU
//   busy       out  frame in progress
//   done       out  load finished OK (sticky until start/rst)
//   error      out  load failed (sticky until start/rst)
//   err_code   out  0 none, 1 timeout, 2 length overflow, 3 checksum mismatch
//   word_count out  words written in the current/last frame
// ---------------------------------------------------------------------------
module uart_mem_loader #(
    parameter int ADDR_W      = 8,
    parameter int WORD_BYTES  = 2,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    rx_ready,
    input  logic [7:0]              rx_data,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_wdata,
    output logic                    cpu_hold,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [1:0]              err_code,
    output logic [ADDR_W:0]         word_count
);
    localparam int DATA_W = 8 * WORD_BYTES;
    localparam int LANE_W = $clog2(WORD_BYTES + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [16:0]       MAX_WORDS = 17'd1 << ADDR_W;
    localparam logic [LANE_W-1:0] LANE_ZERO = LANE_W'(0);
    localparam logic [LANE_W-1:0] LANE_ONE  = LANE_W'(1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(WORD_BYTES - 1);
    localparam logic [TMO_W-1:0]  TMO_ZERO  = TMO_W'(0);
    localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W:0]   WC_ZERO   = (ADDR_W + 1)'(0);
    localparam logic [ADDR_W:0]   WC_ONE    = (ADDR_W + 1)'(1);
    localparam logic [DATA_W-1:0] WORD_ZERO = DATA_W'(0);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [1:0] ERR_CSUM    = 2'd3;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
`ifdef LOADER_CHECKSUM_EN
        , S_CSUM = 3'd6
`endif
    } state_e;

    // State entered once the payload is complete (or N == 0).
`ifdef LOADER_CHECKSUM_EN
    localparam state_e S_TAIL = S_CSUM;
`else
    localparam state_e S_TAIL = S_DONE;
`endif

    // A frame is open in every state except the three resting states.
    function automatic logic is_open(input state_e s);
        return !(s inside {S_IDLE, S_DONE, S_ERR});
    endfunction

    state_e             state_q, state_d;
    logic [15:0]        len_q, len_d;
    logic [DATA_W-1:0]  wbuf_q, wbuf_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [ADDR_W:0]    wc_q, wc_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [1:0]         code_q, code_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    logic [DATA_W-1:0]  word_next_s;
    logic [ADDR_W:0]    wc_inc_s;
    logic [15:0]        len_next_s;
    logic               open_s;
    logic               tmo_hit_s;

    // Next-state and output decode for the frame parser.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wbuf_d      = wbuf_q;
        lane_d      = lane_q;
        wc_d        = wc_q;
        tmo_d       = tmo_q;
        code_d      = code_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        // Word as it stands once the current byte is shifted into the low lane.
        word_next_s = (wbuf_q << 4'd8) | DATA_W'(rx_data);
        wc_inc_s    = wc_q + WC_ONE;
        len_next_s  = {len_q[15:8], rx_data};
        open_s      = is_open(state_q);
        tmo_hit_s   = (tmo_q == TMO_LAST);

        // Inter-byte watchdog: restarts on every accepted byte.
        if (open_s && rx_ready) begin
            tmo_d = TMO_ZERO;
        end else if (open_s) begin
            tmo_d = tmo_q + TMO_ONE;
        end else begin
            tmo_d = tmo_q;
        end

`ifdef LOADER_CHECKSUM_EN
        // Running XOR covers the length bytes and all payload bytes.
        if (open_s && rx_ready) begin
            csum_d = csum_q ^ rx_data;
        end else if (!open_s && start) begin
            csum_d = 8'h00;
        end else begin
            csum_d = csum_q;
        end
`endif

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN_HI;
                    wc_d    = WC_ZERO;
                    lane_d  = LANE_ZERO;
                    wbuf_d  = WORD_ZERO;
                    tmo_d   = TMO_ZERO;
                    code_d  = ERR_NONE;
                end else begin
                    state_d = state_q;
                end
            end
            S_LEN_HI: begin
                if (rx_ready) begin
                    len_d   = {rx_data, len_q[7:0]};
                    state_d = S_LEN_LO;
                end else if (tmo_hit_s) begin
                    state_d = S_ERR;
                    code_d  = ERR_TIMEOUT;
                end else begin
                    state_d = state_q;
                end
            end
            S_LEN_LO: begin
                if (rx_ready) begin
                    len_d = len_next_s;
                    if ({1'b0, len_next_s} > MAX_WORDS) begin
                        state_d = S_ERR;
                        code_d  = ERR_LEN;
                    end else if (len_next_s == 16'd0) begin
                        state_d = S_TAIL;
                    end else begin
                        state_d = S_DATA;
                    end
                end else if (tmo_hit_s) begin
                    state_d = S_ERR;
                    code_d  = ERR_TIMEOUT;
                end else begin
                    state_d = state_q;
                end
            end
            S_DATA: begin
                if (rx_ready) begin
                    wbuf_d = word_next_s;
                    if (lane_q == LANE_LAST) begin
                        // Word complete: register the write in the same edge.
                        lane_d  = LANE_ZERO;
                        we_d    = 1'b1;
                        addr_d  = wc_q[ADDR_W-1:0];
                        wdata_d = word_next_s;
                        wc_d    = wc_inc_s;
                        if (17'(wc_inc_s) == {1'b0, len_q}) begin
                            state_d = S_TAIL;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        lane_d = lane_q + LANE_ONE;
                    end
                end else if (tmo_hit_s) begin
                    state_d = S_ERR;
                    code_d  = ERR_TIMEOUT;
                end else begin
                    state_d = state_q;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (rx_ready) begin
                    if (rx_data == csum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                        code_d  = ERR_CSUM;
                    end
                end else if (tmo_hit_s) begin
                    state_d = S_ERR;
                    code_d  = ERR_TIMEOUT;
                end else begin
                    state_d = state_q;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags follow the state being entered, so they are registered.
        busy_d  = is_open(state_d);
        done_d  = (state_d == S_DONE);
        error_d = (state_d == S_ERR);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= 16'h0000;
            wbuf_q  <= WORD_ZERO;
            lane_q  <= LANE_ZERO;
            wc_q    <= WC_ZERO;
            tmo_q   <= TMO_ZERO;
            code_q  <= ERR_NONE;
            we_q    <= 1'b0;
            addr_q  <= ADDR_W'(0);
            wdata_q <= WORD_ZERO;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wbuf_q  <= wbuf_d;
            lane_q  <= lane_d;
            wc_q    <= wc_d;
            tmo_q   <= tmo_d;
            code_q  <= code_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign cpu_hold   = busy_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign err_code   = code_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// ---------------------------------------------------------------------------
// Self-checking bench for uart_mem_loader. Directed frames from the test plan
// followed by random frames checked against a frame-level reference model.
// Follows LOADER_CHECKSUM_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_uart_mem_loader;
    localparam int ADDR_W     = 8;
    localparam int WORD_BYTES = 2;
    localparam int DATA_W     = 8 * WORD_BYTES;
    localparam int TMO        = 200;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              start    = 1'b0;
    logic              rx_ready = 1'b0;
    logic [7:0]        rx_data  = 8'h00;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   word_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] frame[$];
    int exp_addr[$];
    int exp_data[$];
    int got_addr[$];
    int got_data[$];
    int exp_done, exp_err, exp_code, exp_wc;

    always #5 clk = ~clk;

    uart_mem_loader #(
        .ADDR_W(ADDR_W), .WORD_BYTES(WORD_BYTES), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .rx_ready(rx_ready), .rx_data(rx_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .word_count(word_count)
    );

    // Record every memory write seen on the bus.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            got_addr.push_back(int'(mem_addr));
            got_data.push_back(int'(mem_wdata));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic st);
        rx_data  = b;
        rx_ready = 1'b1;
        start    = st;
        step(1);
        rx_ready = 1'b0;
        start    = 1'b0;
    endtask

    task automatic begin_frame();
        got_addr.delete();
        got_data.delete();
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_hold", 32'(cpu_hold), 32'd1);
        check("start_done", 32'(done), 32'd0);
        check("start_error", 32'(error), 32'd0);
        check("start_wc", 32'(word_count), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_code"}, 32'(err_code), 32'd0);
        check({tag, "_wc"}, 32'(word_count), 32'd0);
    endtask

    // Reference: outcome of a complete frame computed from the frame rules.
    task automatic model();
        int n;
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x;
`endif
        exp_addr.delete();
        exp_data.delete();
        n = int'({frame[0], frame[1]});
        exp_wc = 0; exp_done = 0; exp_err = 0; exp_code = 0;
        if (n > (1 << ADDR_W)) begin
            exp_err  = 1;
            exp_code = 2;
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_addr.push_back(i);
                exp_data.push_back(int'({frame[2 + 2*i], frame[3 + 2*i]}));
            end
            exp_wc = n;
`ifdef LOADER_CHECKSUM_EN
            x = 8'h00;
            for (int i = 0; i < 2 + 2*n; i++) x = x ^ frame[i];
            if (frame[2 + 2*n] == x) begin
                exp_done = 1;
            end else begin
                exp_err  = 1;
                exp_code = 3;
            end
`else
            exp_done = 1;
`endif
        end
    endtask

    task automatic compare_result(input string tag);
        check({tag, "_nwr"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            check({tag, "_wr_addr"}, 32'(got_addr[i]), 32'(exp_addr[i]));
            check({tag, "_wr_data"}, 32'(got_data[i]), 32'(exp_data[i]));
        end
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_error"}, 32'(error), 32'(exp_err));
        check({tag, "_code"}, 32'(err_code), 32'(exp_code));
        check({tag, "_wc"}, 32'(word_count), 32'(exp_wc));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    endtask

    task automatic run_frame(input string tag, input int gap_max, input logic inject);
        int n;
        model();
        begin_frame();
        n = int'({frame[0], frame[1]});
        step(int'($urandom_range(0, gap_max)));
        foreach (frame[i]) begin
            // A start pulse while a frame is open must be ignored.
            send(frame[i], inject && (i == 2) && (n > 0) && (n <= 256));
            step(int'($urandom_range(0, gap_max)));
        end
        step(2);
        compare_result(tag);
        send(8'($urandom_range(0, 255)), 1'b0);
        step(2);
        check({tag, "_extra_nwr"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        check({tag, "_extra_done"}, 32'(done), 32'(exp_done));
        check({tag, "_extra_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset state.
        step(3);
        check_idle_outputs("reset");
        rst = 1'b0;
        step(1);
        send(8'hA5, 1'b0);
        step(2);
        check("idle_byte_busy", 32'(busy), 32'd0);
        check("idle_byte_nwr", 32'(got_addr.size()), 32'd0);

        // Two-word frame at 87-cycle byte spacing with exact timing checks.
        frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef LOADER_CHECKSUM_EN
        frame.push_back(8'h42);
`endif
        begin_frame();
        foreach (frame[i]) begin
            send(frame[i], 1'b0);
            if (i == 3) begin
                check("w0_we", 32'(mem_we), 32'd1);
                check("w0_addr", 32'(mem_addr), 32'd0);
                check("w0_data", 32'(mem_wdata), 32'h1234);
                check("w0_wc", 32'(word_count), 32'd1);
            end
            if (i == 5) begin
                check("w1_we", 32'(mem_we), 32'd1);
                check("w1_addr", 32'(mem_addr), 32'd1);
                check("w1_data", 32'(mem_wdata), 32'hABCD);
            end
            if (i == frame.size() - 1) begin
                check("t1_done", 32'(done), 32'd1);
                check("t1_hold", 32'(cpu_hold), 32'd0);
                check("t1_busy", 32'(busy), 32'd0);
                check("t1_error", 32'(error), 32'd0);
                check("t1_wc", 32'(word_count), 32'd2);
            end else begin
                step(86);
            end
        end
        step(2);
        check("t1_nwr", 32'(got_addr.size()), 32'd2);

`ifdef LOADER_CHECKSUM_EN
        // Same frame with a wrong checksum.
        frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
        run_frame("badsum", 4, 1'b0);
`else
        // One-word frame: write and done on the edge of the last byte.
        frame = '{8'h00, 8'h01, 8'hBE, 8'hEF};
        begin_frame();
        foreach (frame[i]) send(frame[i], 1'b0);
        check("beef_we", 32'(mem_we), 32'd1);
        check("beef_addr", 32'(mem_addr), 32'd0);
        check("beef_data", 32'(mem_wdata), 32'hBEEF);
        check("beef_done", 32'(done), 32'd1);
        send(8'h77, 1'b0);
        step(2);
        check("beef_extra_nwr", 32'(got_addr.size()), 32'd1);
        check("beef_extra_done", 32'(done), 32'd1);
`endif

        // Length overflow: 257 words.
        begin_frame();
        send(8'h01, 1'b0);
        send(8'h01, 1'b0);
        check("ovf_error", 32'(error), 32'd1);
        check("ovf_code", 32'(err_code), 32'd2);
        check("ovf_hold", 32'(cpu_hold), 32'd0);
        check("ovf_done", 32'(done), 32'd0);
        step(3);
        check("ovf_nwr", 32'(got_addr.size()), 32'd0);

        // Timeout: a byte on the expiry cycle wins, then silence expires.
        begin_frame();
        send(8'h00, 1'b0);
        step(TMO - 1);
        check("tmo_pre_error", 32'(error), 32'd0);
        send(8'h01, 1'b0);
        check("tmo_win_error", 32'(error), 32'd0);
        check("tmo_win_busy", 32'(busy), 32'd1);
        send(8'h55, 1'b0);
        step(TMO - 1);
        check("tmo_early_error", 32'(error), 32'd0);
        check("tmo_early_busy", 32'(busy), 32'd1);
        step(1);
        check("tmo_error", 32'(error), 32'd1);
        check("tmo_code", 32'(err_code), 32'd1);
        check("tmo_hold", 32'(cpu_hold), 32'd0);
        check("tmo_nwr", 32'(got_addr.size()), 32'd0);

        // Reset between the third and fourth data bytes of a two-word frame.
        begin_frame();
        frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
        foreach (frame[i]) begin
            send(frame[i], 1'b0);
            step(3);
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_idle_outputs("rst_mid");
        send(8'hCD, 1'b0);
        send(8'h00, 1'b0);
        send(8'h01, 1'b0);
        step(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_nwr", 32'(got_addr.size()), 32'd1);
        if (got_addr.size() > 0) begin
            check("rst_wr_addr", 32'(got_addr[0]), 32'd0);
            check("rst_wr_data", 32'(got_data[0]), 32'h1234);
        end

        // Largest frame (256 words), bytes back to back.
        frame.delete();
        frame.push_back(8'h01);
        frame.push_back(8'h00);
        for (int i = 0; i < 512; i++) frame.push_back(8'($urandom_range(0, 255)));
`ifdef LOADER_CHECKSUM_EN
        begin
            logic [7:0] xs;
            xs = 8'h00;
            foreach (frame[i]) xs = xs ^ frame[i];
            frame.push_back(xs);
        end
`endif
        run_frame("max", 0, 1'b0);

        // Random frames.
        for (int f = 0; f < 20; f++) begin
            int n;
            frame.delete();
            if ($urandom_range(0, 7) == 0) n = int'($urandom_range(257, 65535));
            else n = int'($urandom_range(0, 6));
            frame.push_back(8'(n >> 8));
            frame.push_back(8'(n));
            if (n <= 256) begin
                for (int i = 0; i < 2*n; i++) frame.push_back(8'($urandom_range(0, 255)));
`ifdef LOADER_CHECKSUM_EN
                begin
                    logic [7:0] xr;
                    xr = 8'h00;
                    foreach (frame[i]) xr = xr ^ frame[i];
                    if ($urandom_range(0, 3) == 0) xr = xr ^ 8'($urandom_range(1, 255));
                    frame.push_back(xr);
                end
`endif
            end
            run_frame("rand", 6, ($urandom_range(0, 1) == 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
Sequences the UART receive path to boot the processor. Consumes byte strobes from async_receiver, parses a length-prefixed frame, packs bytes into memory words and issues write strobes to instruction/data memory. Holds the CPU in stall until the load completes or fails. Sits between async_receiver and the memory write port; the CPU regains the port when cpu_hold drops.

Parameters:
ADDR_W, 8, memory word-address width; max frame = 2^ADDR_W words
WORD_BYTES, 2, bytes per memory word; DATA_W = 8*WORD_BYTES
TIMEOUT_CYC, 1000000, max clk cycles between accepted bytes while a frame is open (100 ms at 10 MHz)

Ports:
clk  in  1  system clock, 10 MHz nominal
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; arms loader (ignored while busy)
rx_ready  in  1  one-cycle strobe from async_receiver, byte valid
rx_data  in  8  received byte, valid with rx_ready
mem_we  out  1  memory write strobe, one cycle per word
mem_addr  out  ADDR_W  word address for mem_we
mem_wdata  out  DATA_W  word data for mem_we
cpu_hold  out  1  stall request to CPU
busy  out  1  frame in progress
done  out  1  load finished OK; sticky until next start or rst
error  out  1  load failed; sticky until next start or rst
err_code  out  2  0 none, 1 timeout, 2 length overflow, 3 checksum mismatch
word_count  out  ADDR_W+1  words written in current/last frame

Behaviour:
- Clock clk, reset rst: synchronous, active-high; all registers update on rising clk edge only.
- Reset values: all outputs 0; state IDLE; counters and checksum 0.
- Frame: LEN_HI, LEN_LO (word count N, big-endian), N*WORD_BYTES data bytes, then checksum byte (if enabled).
- States: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
- IDLE: start -> LEN_HI; clear done, error, err_code, word_count, checksum, byte lane; assert cpu_hold, busy next cycle. rx_ready in IDLE, DONE or ERR ignored.
- LEN_HI: rx_ready -> capture high byte -> LEN_LO.
- LEN_LO: rx_ready -> capture low byte; N > 2^ADDR_W -> ERR, code 2; N == 0 -> CSUM (or DONE without macro); else DATA.
- DATA: each rx_ready shifts byte into word buffer, first byte to MSB lane. On the byte completing a word, next cycle: mem_we=1, mem_addr=word_count[ADDR_W-1:0], mem_wdata=assembled word, word_count increments. Last word -> CSUM (or DONE). No byte lost: assembly and write registration happen in the same edge.
- CSUM: running XOR of all bytes from LEN_HI on; rx_ready byte equal to running XOR -> DONE, else ERR code 3.
- DONE: done=1, busy=0, cpu_hold=0 on the cycle after the final accepted byte's edge. ERR: error=1, err_code set, busy=0, cpu_hold=0.
- start in DONE or ERR behaves as in IDLE (restart). start while busy: ignored.
- Timeout: counter cleared on start and every accepted rx_ready; counts in LEN_HI..CSUM; reaching TIMEOUT_CYC-1 -> ERR code 1. rx_ready on that same cycle wins (byte accepted, counter cleared).
- Memory words already written before ERR stay written; no rollback.
- rst mid-frame: immediate return to IDLE; cpu_hold drops; partial word discarded, no mem_we.

Optional Feature:
LOADER_CHECKSUM_EN: defined -> CSUM state present, trailing checksum byte required, err_code 3 possible. Undefined -> CSUM omitted; final data word (or N==0 after LEN_LO) goes directly to DONE; err_code 3 never produced; checksum logic not synthesised.

Test Plan:
- Macro on; start, then bytes 0x00 0x02 0x12 0x34 0xAB 0xCD 0x42 at 87-cycle spacing -> mem_we at addr 0 data 0x1234, addr 1 data 0xABCD, done=1, word_count=2, cpu_hold 0 after last byte.
- Same frame with checksum 0x43 -> both writes occur, error=1, err_code=3, done=0.
- Length 0x01 0x01 (257) with ADDR_W=8 -> ERR code 2 after LEN_LO, no mem_we.
- start, 0x00 0x01 0x55, then silence -> error=1, err_code=1 exactly TIMEOUT_CYC cycles after 0x55 byte; no mem_we.
- rst asserted between bytes 3 and 4 of a 2-word frame -> one mem_we (addr 0) only, all outputs 0 next cycle; rx_ready bytes afterward ignored until start.
- Macro off; frame 0x00 0x01 0xBE 0xEF -> mem_we addr 0 data 0xBEEF, done=1 the following cycle; extra byte afterward ignored.
